// File: rtl/dec_pkg.sv
// Shared types for the scan decoder: FSM state encoding and mode select values.
package dec_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_MANUAL,
    ST_SCAN
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// Step-rate divider for scan mode: counts 0..PRESCALE-1 while run is high.
// tick flags the terminal count; the owner decides whether that count is consumed.
module scan_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reported ungated so the parent's run decision never loops back through this port.
  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with enable, manual select and auto-scan mode.
// The FSM, index/output/wrap registers and the one-hot decode live here.
module scan_decoder
  import dec_pkg::*;
#(
  parameter  int SEL_W    = 2,
  parameter  int PRESCALE = 4,
  localparam int N_OUT    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             hold,
  output logic [N_OUT-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [N_OUT-1:0] ONE = N_OUT'(1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic             pre_clr, pre_run, pre_tick;

  scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .run (pre_run),
    .tick(pre_tick)
  );

  always_comb begin
    state_d = ST_OFF;
    pre_clr = 1'b0;
    pre_run = 1'b0;
    idx_d   = idx_q;
    y_d     = y_q;
    wrap_d  = 1'b0;

    if (en) begin
      case (mode)
        MODE_MANUAL: state_d = ST_MANUAL;
        MODE_SCAN:   state_d = ST_SCAN;
        default:     state_d = ST_OFF;
      endcase
    end

    case (state_d)
      ST_OFF: begin
        y_d = '0;
      end
      ST_MANUAL: begin
        pre_clr = 1'b1;
        idx_d   = sel;
        y_d     = ONE << sel;
      end
      ST_SCAN: begin
        // Entry restarts the dwell at the index already held, so the scan resumes in place.
        if (state_q != ST_SCAN) begin
          pre_clr = 1'b1;
          y_d     = ONE << idx_q;
        end else if (!hold) begin
          pre_run = 1'b1;
          if (pre_tick) begin
            idx_d  = idx_q + SEL_W'(1);
            y_d    = ONE << idx_d;
            wrap_d = (idx_q == '1);
          end
        end
      end
      default: begin
        y_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: two instances (2-bit select / 3-cycle dwell and
// 3-bit select / 1-cycle dwell) share control inputs and are checked against a step model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode, hold;
  logic [1:0] sel0;
  logic [2:0] sel1;
  logic [3:0] y0;
  logic [1:0] idx0;
  logic       wrap0;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       wrap1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] y0;
    logic [2:0] idx0;
    logic       w0;
    logic [7:0] y1;
    logic [2:0] idx1;
    logic       w1;
  } exp_t;

  exp_t exp_q[$];

  int m_idx[2];
  int m_dwell[2];
  bit m_on[2];
  bit m_scan[2];
  bit m_wrap[2];
  int n_out[2] = '{4, 8};
  int dwell[2] = '{3, 1};

  scan_decoder #(.SEL_W(2), .PRESCALE(3)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel0), .hold(hold),
    .y(y0), .idx(idx0), .wrap(wrap0)
  );

  scan_decoder #(.SEL_W(3), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel1), .hold(hold),
    .y(y1), .idx(idx1), .wrap(wrap1)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] model_y(int d);
    return m_on[d] ? 8'(1 << m_idx[d]) : 8'h00;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 0; m_dwell[d] = 0; m_on[d] = 0; m_scan[d] = 0; m_wrap[d] = 0;
    end
  endtask

  // One clock of behaviour: each scan step lasts `dwell` cycles after the entry cycle.
  task automatic model_step(int d, int s);
    m_wrap[d] = 0;
    if (!en) begin
      m_on[d] = 0; m_scan[d] = 0;
    end else if (!mode) begin
      m_idx[d] = s % n_out[d]; m_on[d] = 1; m_scan[d] = 0;
    end else if (!m_scan[d]) begin
      m_scan[d] = 1; m_dwell[d] = 0; m_on[d] = 1;
    end else if (!hold) begin
      m_dwell[d]++;
      if (m_dwell[d] == dwell[d]) begin
        m_dwell[d] = 0;
        m_wrap[d]  = (m_idx[d] == n_out[d] - 1);
        m_idx[d]   = (m_idx[d] + 1) % n_out[d];
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.y0 = model_y(0); e.idx0 = 3'(m_idx[0]); e.w0 = m_wrap[0];
    e.y1 = model_y(1); e.idx1 = 3'(m_idx[1]); e.w1 = m_wrap[1];
    exp_q.push_back(e);
  endtask

  task automatic check_output(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic apply_stimulus(logic e, logic m, logic h, int s0, int s1);
    @(negedge clk);
    rst = 1'b0; en = e; mode = m; hold = h;
    sel0 = 2'(s0); sel1 = 3'(s1);
    model_step(0, s0);
    model_step(1, s1);
    push_expected();
  endtask

  task automatic check_reset_state(string tag);
    check_output({tag, "_y0"},    8'(y0),    8'h00);
    check_output({tag, "_idx0"},  8'(idx0),  8'h00);
    check_output({tag, "_wrap0"}, 8'(wrap0), 8'h00);
    check_output({tag, "_y1"},    y1,        8'h00);
    check_output({tag, "_idx1"},  8'(idx1),  8'h00);
    check_output({tag, "_wrap1"}, 8'(wrap1), 8'h00);
  endtask

  // Asserts reset between clock edges and checks that outputs clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_state("async_rst");
    push_expected();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("y0",    8'(y0),    e.y0);
        check_output("idx0",  8'(idx0),  8'(e.idx0));
        check_output("wrap0", 8'(wrap0), 8'(e.w0));
        check_output("y1",    y1,        e.y1);
        check_output("idx1",  8'(idx1),  8'(e.idx1));
        check_output("wrap1", 8'(wrap1), 8'(e.w1));
      end
    end
  end

  initial begin : driver
    int r;
    rst = 1'b0; en = 1'b0; mode = 1'b0; hold = 1'b0; sel0 = '0; sel1 = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_reset_state("init_rst");

    repeat (2) apply_stimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      repeat (2) apply_stimulus(1, 0, 0, i, 2 * i + 1);
    end

    repeat (2) apply_stimulus(1, 0, 0, 2, 2);
    repeat (16) apply_stimulus(1, 1, 0, $urandom_range(0, 3), $urandom_range(0, 7));

    repeat (5) apply_stimulus(1, 1, 1, 0, 0);
    repeat (2) apply_stimulus(0, 1, 0, 0, 0);
    repeat (8) apply_stimulus(1, 1, 0, 0, 0);

    async_reset();
    repeat (4) apply_stimulus(1, 1, 0, 3, 7);
    repeat (2) apply_stimulus(1, 0, 0, 1, 5);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        async_reset();
      end else begin
        apply_stimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 99) < 15), $urandom_range(0, 3),
                       $urandom_range(0, 7));
      end
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
